// File: rtl/mvm_pkg.sv
// Shared types and defaults for the MVM accelerator host link.
// Indices are 2 bits wide, so at most a 4x4 matrix.
package mvm_pkg;

    localparam int IDX_W = 2;
    localparam int DATA_W = 8;
    localparam int TMO_W = 24;
    localparam int MAX_N = 1 << IDX_W;
    localparam int N_DEF = 4;
    localparam logic [TMO_W-1:0] TIMEOUT_DEF = 24'd10_000_000;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_M,
        SEND_V,
        COLLECT,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mvm_timeout_ctr.sv
// Idle-cycle watchdog for host-side links.
// Raises expired on the cycle whose increment would reach LIMIT.
module mvm_timeout_ctr
    import mvm_pkg::*;
#(
    parameter logic [TMO_W-1:0] LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = LIMIT - TMO_W'(1);

    logic [TMO_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + TMO_W'(1);
        end
    end

    assign expired = en & ~clr & (count_q == LAST);

endmodule

// File: rtl/mvm_host_link.sv
// Host-side streamer for the MVM accelerator pin protocol.
// Sends M then V as indexed beats, then collects N results.
module mvm_host_link
    import mvm_pkg::*;
#(
    parameter int N = N_DEF,
    parameter logic [TMO_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_en,
    input  logic        ld_sel,
    input  logic [3:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    input  logic [1:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [7:0]  acc_value,
    output logic [1:0]  acc_row,
    output logic [1:0]  acc_col,
    output logic        acc_sending_cpu,
    output logic        acc_done_list,
    input  logic        acc_fetch_ready,
    input  logic        acc_sending_out,
    input  logic [7:0]  acc_output_val
);

    localparam idx_t LAST = idx_t'(N - 1);

    state_t state_q, state_n;
    idx_t   row_q, row_n;
    idx_t   col_q, col_n;
    idx_t   cap_q, cap_n;

    data_t  m_q [MAX_N][MAX_N];
    data_t  v_q [MAX_N];
    data_t  r_q [MAX_N];

    data_t  val_n;
    idx_t   arow_n, acol_n;
    logic   snd_n, dl_n;

    logic   xfer, accept, capture;
    logic   tmo_clr, tmo_en, tmo_exp;
    logic   ld_ok, ld_in_range;
    idx_t   ld_row, ld_col;

    assign ld_row = ld_addr[3:2];
    assign ld_col = ld_addr[1:0];
    assign ld_ok  = ld_en & ((state_q == IDLE) | (state_q == ERR));
    assign ld_in_range = ld_sel ? (int'(ld_col) < N)
                                : (int'(ld_row) < N) && (int'(ld_col) < N);

    mvm_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_exp)
    );

    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        col_n   = col_q;
        cap_n   = cap_q;
        accept  = 1'b0;
        capture = 1'b0;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        xfer    = acc_sending_cpu & acc_fetch_ready;
        unique case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    accept  = 1'b1;
                    tmo_clr = 1'b1;
                    row_n   = '0;
                    col_n   = '0;
                    cap_n   = '0;
                    state_n = SEND_M;
                end
            end
            SEND_M: begin
                tmo_en = 1'b1;
                if (xfer) begin
                    tmo_clr = 1'b1;
                    if (col_q == LAST) begin
                        col_n = '0;
                        if (row_q == LAST) begin
                            row_n   = '0;
                            state_n = SEND_V;
                        end else begin
                            row_n = row_q + idx_t'(1);
                        end
                    end else begin
                        col_n = col_q + idx_t'(1);
                    end
                end
            end
            SEND_V: begin
                tmo_en = 1'b1;
                if (xfer) begin
                    tmo_clr = 1'b1;
                    if (col_q == LAST) begin
                        col_n   = '0;
                        state_n = COLLECT;
                    end else begin
                        col_n = col_q + idx_t'(1);
                    end
                end
            end
            COLLECT: begin
                tmo_en = 1'b1;
                if (acc_sending_out) begin
                    capture = 1'b1;
                    tmo_clr = 1'b1;
                    cap_n   = cap_q + idx_t'(1);
                    if (cap_q == LAST) state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo_exp) state_n = ERR;

        // Pins are registered from the next state so a stall re-presents the same beat.
        val_n  = '0;
        arow_n = '0;
        acol_n = '0;
        snd_n  = 1'b0;
        dl_n   = 1'b0;
        if (state_n == SEND_M) begin
            snd_n  = 1'b1;
            arow_n = row_n;
            acol_n = col_n;
            val_n  = m_q[row_n][col_n];
        end else if (state_n == SEND_V) begin
            snd_n  = 1'b1;
            dl_n   = 1'b1;
            acol_n = col_n;
            val_n  = v_q[col_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            row_q           <= '0;
            col_q           <= '0;
            cap_q           <= '0;
            acc_value       <= '0;
            acc_row         <= '0;
            acc_col         <= '0;
            acc_sending_cpu <= 1'b0;
            acc_done_list   <= 1'b0;
        end else begin
            state_q         <= state_n;
            row_q           <= row_n;
            col_q           <= col_n;
            cap_q           <= cap_n;
            acc_value       <= val_n;
            acc_row         <= arow_n;
            acc_col         <= acol_n;
            acc_sending_cpu <= snd_n;
            acc_done_list   <= dl_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_N; r++) begin
                v_q[r] <= '0;
                r_q[r] <= '0;
                for (int c = 0; c < MAX_N; c++) m_q[r][c] <= '0;
            end
        end else begin
            if (ld_ok && ld_in_range) begin
                if (ld_sel) v_q[ld_col] <= ld_data;
                else        m_q[ld_row][ld_col] <= ld_data;
            end
            if (accept) begin
                for (int r = 0; r < MAX_N; r++) r_q[r] <= '0;
            end else if (capture) begin
                r_q[cap_q] <= acc_output_val;
            end
        end
    end

    assign busy        = (state_q == SEND_M) | (state_q == SEND_V) | (state_q == COLLECT);
    assign done        = (state_q == DONE);
    assign timeout_err = (state_q == ERR);
    assign rd_data     = (int'(rd_addr) < N) ? r_q[rd_addr] : '0;

endmodule

// File: tb/tb_mvm_host_link.sv
// Directed bench for mvm_host_link: N=4 and N=2 instances on a shared host bus.
// Checks beat order, stalls, timeout, ignored strobes, async reset and readback.
module tb_mvm_host_link;
    import mvm_pkg::*;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic       dl;
        logic [7:0] val;
    } beat_t;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } rd_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ld_en, ld_sel, start4, start2;
    logic [3:0] ld_addr;
    logic [7:0] ld_data, acc_output_val;
    logic [1:0] rd_addr;
    logic       acc_fetch_ready, acc_sending_out;

    logic       busy4, done4, err4, snd4, dl4;
    logic [7:0] rd4, val4;
    logic [1:0] row4, col4;
    logic       busy2, done2, err2, snd2, dl2;
    logic [7:0] rd2, val2;
    logic [1:0] row2, col2;

    mvm_host_link #(.N(4), .TIMEOUT(24'd100)) u4 (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start4), .busy(busy4), .done(done4), .timeout_err(err4),
        .rd_addr(rd_addr), .rd_data(rd4),
        .acc_value(val4), .acc_row(row4), .acc_col(col4),
        .acc_sending_cpu(snd4), .acc_done_list(dl4),
        .acc_fetch_ready(acc_fetch_ready), .acc_sending_out(acc_sending_out),
        .acc_output_val(acc_output_val)
    );

    mvm_host_link #(.N(2), .TIMEOUT(24'd100)) u2 (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start2), .busy(busy2), .done(done2), .timeout_err(err2),
        .rd_addr(rd_addr), .rd_data(rd2),
        .acc_value(val2), .acc_row(row2), .acc_col(col2),
        .acc_sending_cpu(snd2), .acc_done_list(dl2),
        .acc_fetch_ready(acc_fetch_ready), .acc_sending_out(acc_sending_out),
        .acc_output_val(acc_output_val)
    );

    int      tests = 0;
    int      fails = 0;
    int      cyc = 0;
    logic [7:0] tb_m [4][4];
    logic [7:0] tb_v [4];
    logic [7:0] res [4];
    beat_t   exp4 [20];
    beat_t   exp2 [6];
    rd_vec_t rdv [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        ld_en = 1'b1;
        ld_sel = sel;
        ld_addr = addr;
        ld_data = data;
        if (sel) tb_v[addr[1:0]] = data;
        else     tb_m[addr[3:2]][addr[1:0]] = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic build_exp4();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp4[i] = '{2'(i / 4), 2'(i % 4), 1'b0, tb_m[i / 4][i % 4]};
            else        exp4[i] = '{2'd0, 2'(i - 16), 1'b1, tb_v[i - 16]};
        end
    endtask

    task automatic check_rd4(input string name);
        for (int i = 0; i < 4; i++) rdv[i] = '{2'(i), res[i]};
        for (int i = 0; i < 4; i++) begin
            rd_addr = rdv[i].addr;
            #1;
            check($sformatf("%s_rd%0d", name, i), rd4, rdv[i].data);
        end
    endtask

    task automatic stream4(input bit toggle, input bit poke, output int last);
        int nb;
        nb = 0;
        last = 0;
        build_exp4();
        cyc = 0;
        acc_fetch_ready = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("busy_rise", busy4, 1);
        check("err_clear", err4, 0);
        while (nb < 20 && cyc < 300) begin
            acc_fetch_ready = toggle ? cyc[0] : 1'b1;
            if (poke && cyc == 3) begin
                start4 = 1'b1;
                ld_en = 1'b1;
                ld_sel = 1'b0;
                ld_addr = 4'hF;
                ld_data = 8'hEE;
            end else if (poke && cyc == 4) begin
                start4 = 1'b0;
                ld_en = 1'b0;
            end
            if (snd4 && acc_fetch_ready) begin
                check($sformatf("beat%0d", nb), {row4, col4, dl4, val4},
                      {exp4[nb].row, exp4[nb].col, exp4[nb].dl, exp4[nb].val});
                nb++;
                last = cyc;
            end
            tick();
        end
        check("beat_count", nb, 20);
        acc_fetch_ready = 1'b0;
        check("collect_cpu_low", snd4, 0);
        check("collect_busy", busy4, 1);
    endtask

    task automatic collect4(input string name);
        for (int k = 0; k < 4; k++) begin
            acc_sending_out = 1'b1;
            acc_output_val = res[k];
            tick();
            if (k < 3) check($sformatf("%s_done_early%0d", name, k), done4, 0);
        end
        acc_sending_out = 1'b0;
        acc_output_val = 8'h00;
        check({name, "_done"}, done4, 1);
        check({name, "_busy_fall"}, busy4, 0);
        tick();
        check({name, "_done_pulse"}, done4, 0);
        check_rd4(name);
    endtask

    int last;

    initial begin
        rst_n = 1'b0;
        ld_en = 1'b0;
        ld_sel = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        start4 = 1'b0;
        start2 = 1'b0;
        rd_addr = '0;
        acc_fetch_ready = 1'b0;
        acc_sending_out = 1'b0;
        acc_output_val = '0;
        for (int r = 0; r < 4; r++) begin
            tb_v[r] = '0;
            for (int c = 0; c < 4; c++) tb_m[r][c] = '0;
        end

        repeat (2) tick();
        check("rst_status", {busy4, done4, err4}, 0);
        check("rst_pins", {val4, row4, col4, snd4, dl4}, 0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_status", {busy4, done4, err4}, 0);

        // identity matrix, V = 1..4, ready held high
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                load(1'b0, 4'({r[1:0], c[1:0]}), (r == c) ? 8'd1 : 8'd0);
        for (int i = 0; i < 4; i++) load(1'b1, 4'(i), 8'(i + 1));
        stream4(1'b0, 1'b0, last);
        check("last_beat_cycle", last, 20);
        check("collect_cycle", cyc, 21);
        res = '{8'd1, 8'd2, 8'd3, 8'd4};
        collect4("ident");

        // distinct pattern, ready toggling, start/ld pulses mid-stream
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                load(1'b0, 4'({r[1:0], c[1:0]}), 8'(8'h10 * (r + 1) + c + 3));
        for (int i = 0; i < 4; i++) load(1'b1, 4'(i), 8'(8'hA0 + i));
        stream4(1'b1, 1'b1, last);
        check("toggle_last_beat", last, 39);
        res = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
        collect4("toggle");

        // stall forever -> timeout
        cyc = 0;
        acc_fetch_ready = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        while (!err4 && cyc < 300) tick();
        check("timeout_cycle", cyc, 101);
        check("err_busy", busy4, 0);
        check("err_pins", {val4, row4, col4, snd4, dl4}, 0);
        tick();
        check("err_sticky", err4, 1);

        // restart from ERR, M[3][3] must still hold its loaded value
        stream4(1'b0, 1'b0, last);
        check("restart_last_beat", last, 20);
        res = '{8'h81, 8'h42, 8'h24, 8'h18};
        collect4("restart");

        // async reset at beat 7
        cyc = 0;
        acc_fetch_ready = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (6) tick();
        check("beat7_index", {row4, col4}, {2'd1, 2'd2});
        #2 rst_n = 1'b0;
        #1;
        check("arst_status", {busy4, done4, err4}, 0);
        check("arst_pins", {val4, row4, col4, snd4, dl4}, 0);
        res = '{8'h00, 8'h00, 8'h00, 8'h00};
        check_rd4("arst");
        tick();
        #2 rst_n = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
            tb_v[r] = '0;
            for (int c = 0; c < 4; c++) tb_m[r][c] = '0;
        end
        stream4(1'b0, 1'b0, last);
        res = '{8'h11, 8'h22, 8'h33, 8'h44};
        collect4("cleared");

        // N = 2 instance
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                load(1'b0, 4'({r[1:0], c[1:0]}), 8'(8'h60 + r * 2 + c));
        for (int i = 0; i < 2; i++) load(1'b1, 4'(i), 8'(8'h70 + i));
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp2[i] = '{2'(i / 2), 2'(i % 2), 1'b0, tb_m[i / 2][i % 2]};
            else       exp2[i] = '{2'd0, 2'(i - 4), 1'b1, tb_v[i - 4]};
        end
        begin
            int nb;
            nb = 0;
            cyc = 0;
            acc_fetch_ready = 1'b1;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            check("n2_busy", busy2, 1);
            while (nb < 6 && cyc < 100) begin
                if (snd2) begin
                    check($sformatf("n2_beat%0d", nb), {row2, col2, dl2, val2},
                          {exp2[nb].row, exp2[nb].col, exp2[nb].dl, exp2[nb].val});
                    nb++;
                end
                tick();
            end
            check("n2_beat_count", nb, 6);
            check("n2_collect_cycle", cyc, 7);
            check("n2_cpu_low", snd2, 0);
        end
        acc_sending_out = 1'b1;
        acc_output_val = 8'hC3;
        tick();
        check("n2_done_early", done2, 0);
        acc_output_val = 8'h3C;
        tick();
        acc_sending_out = 1'b0;
        check("n2_done", done2, 1);
        check("n2_busy_fall", busy2, 0);
        rdv = '{'{2'd0, 8'hC3}, '{2'd1, 8'h3C}, '{2'd2, 8'h00}, '{2'd3, 8'h00}};
        for (int i = 0; i < 4; i++) begin
            rd_addr = rdv[i].addr;
            #1;
            check($sformatf("n2_rd%0d", i), rd2, rdv[i].data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end

endmodule
